// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: ADC FIFO, general-byte and UART handshake bundle for uart_tx_arbiter.
// master drives the FIFO/general/UART inputs; slave is the arbiter itself.
interface uart_tx_arbiter_if;
    logic       adc_empty;
    logic [7:0] adc_data;
    logic       adc_rd_en;
    logic [7:0] gen_data;
    logic       gen_write;
    logic       gen_busy;
    logic       tx_ready;
    logic       tx_start;
    logic [7:0] tx_data;
    logic       burst_active;
    modport master (
        output adc_empty, adc_data, gen_data, gen_write, tx_ready,
        input  adc_rd_en, gen_busy, tx_start, tx_data, burst_active
    );
    modport slave (
        input  adc_empty, adc_data, gen_data, gen_write, tx_ready,
        output adc_rd_en, gen_busy, tx_start, tx_data, burst_active
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART between a general hold byte and uninterruptible ADC bursts.
// Define TX_BURST_HEADER_EN to prefix every burst with header byte 8'hA5.
module uart_tx_arbiter #(
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned STALL_MAX = 1023
) (
    input logic               clk_i,
    input logic               rst_ni,
    uart_tx_arbiter_if.slave  bus
);
    localparam int unsigned SW = $clog2(STALL_MAX + 1);
`ifdef TX_BURST_HEADER_EN
    typedef enum logic [2:0] {IDLE, GEN_SEND, HDR_SEND, ADC_FETCH, ADC_LATCH, ADC_SEND, TX_WAIT} state_t;
    localparam state_t BURST_FIRST = HDR_SEND;
`else
    typedef enum logic [2:0] {IDLE, GEN_SEND, ADC_FETCH, ADC_LATCH, ADC_SEND, TX_WAIT} state_t;
    localparam state_t BURST_FIRST = ADC_FETCH;
`endif
    state_t        state_q;
    logic          run_q;
    logic          guard_q;
    logic          tx_start_q;
    logic          adc_rd_en_q;
    logic          gen_busy_q;
    logic          burst_q;
    logic [7:0]    hold_q;
    logic [7:0]    tx_data_q;
    logic [7:0]    cnt_q;
    logic [SW-1:0] stall_q;
    // run_q delays the first state change to the second edge after reset release
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            run_q       <= 1'b0;
            guard_q     <= 1'b0;
            tx_start_q  <= 1'b0;
            adc_rd_en_q <= 1'b0;
            gen_busy_q  <= 1'b0;
            burst_q     <= 1'b0;
            hold_q      <= 8'h00;
            tx_data_q   <= 8'h00;
            cnt_q       <= 8'h00;
            stall_q     <= '0;
        end else begin
            run_q       <= 1'b1;
            tx_start_q  <= 1'b0;
            adc_rd_en_q <= 1'b0;
            if (run_q) begin
                if (bus.gen_write && !gen_busy_q) begin
                    hold_q     <= bus.gen_data;
                    gen_busy_q <= 1'b1;
                end
                case (state_q)
                    IDLE:
                        if (gen_busy_q) state_q <= GEN_SEND;
                        else if (!bus.adc_empty) begin
                            cnt_q   <= 8'h00;
                            stall_q <= '0;
                            burst_q <= 1'b1;
                            state_q <= BURST_FIRST;
                        end
                    GEN_SEND:
                        if (bus.tx_ready) begin
                            tx_data_q  <= hold_q;
                            tx_start_q <= 1'b1;
                            gen_busy_q <= 1'b0;
                            guard_q    <= 1'b1;
                            state_q    <= TX_WAIT;
                        end
`ifdef TX_BURST_HEADER_EN
                    HDR_SEND:
                        if (bus.tx_ready) begin
                            tx_data_q  <= 8'hA5;
                            tx_start_q <= 1'b1;
                            guard_q    <= 1'b1;
                            state_q    <= TX_WAIT;
                        end
`endif
                    ADC_FETCH:
                        if (!bus.adc_empty) begin
                            adc_rd_en_q <= 1'b1;
                            stall_q     <= '0;
                            state_q     <= ADC_LATCH;
                        end else begin
                            stall_q <= stall_q + 1'b1;
                            if (stall_q == SW'(STALL_MAX - 1)) begin
                                burst_q <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    // FIFO data is valid only once the read strobe has been retired
                    ADC_LATCH:
                        if (!adc_rd_en_q) begin
                            tx_data_q <= bus.adc_data;
                            state_q   <= ADC_SEND;
                        end
                    ADC_SEND:
                        if (bus.tx_ready) begin
                            tx_start_q <= 1'b1;
                            cnt_q      <= (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'h01;
                            guard_q    <= 1'b1;
                            state_q    <= TX_WAIT;
                        end
                    TX_WAIT:
                        if (guard_q) guard_q <= 1'b0;
                        else if (bus.tx_ready) begin
                            if (burst_q && cnt_q < 8'(BURST_LEN)) state_q <= ADC_FETCH;
                            else begin
                                burst_q <= 1'b0;
                                state_q <= IDLE;
                            end
                        end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end
    assign bus.adc_rd_en    = adc_rd_en_q;
    assign bus.gen_busy     = gen_busy_q;
    assign bus.tx_start     = tx_start_q;
    assign bus.tx_data      = tx_data_q;
    assign bus.burst_active = burst_q;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: random FIFO/UART traffic against a byte-sequence reference model.
module tb_uart_tx_arbiter;
    localparam int BL = 16;
    localparam int SM = 1023;
`ifdef TX_BURST_HEADER_EN
    localparam int HDR = 1;
`else
    localparam int HDR = 0;
`endif
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    uart_tx_arbiter_if bus();
    uart_tx_arbiter #(.BURST_LEN(BL), .STALL_MAX(SM)) dut (.clk_i(clk), .rst_ni(rst_n), .bus(bus));
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    logic [7:0] fifo[$];
    logic [7:0] src[$];
    logic [7:0] rx[$];
    logic [7:0] exp_q[$];
    int busy = 0, busy_time = 10;
    int cyc = 0, last_rd_cyc = 0, drop_cyc = 0;
    int n_rd = 0, n_bursts = 0;
    int hold_starts = 0, hold_rd = 0, hold_chg = 0, busy_drop = 0;
    bit hold_low = 0, watch_busy = 0;
    bit prev_start = 0, prev_burst = 0;
    logic [7:0] hold_data = 8'h00;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
        end
    endtask

    // FIFO, UART and protocol monitor; everything updates on the falling edge
    always @(negedge clk) begin
        cyc++;
        if (bus.adc_rd_en) begin
            check("rd_while_empty", fifo.size() != 0, 1);
            n_rd++;
            last_rd_cyc = cyc;
            if (fifo.size() != 0) bus.adc_data = fifo.pop_front();
        end
        if (bus.tx_start) begin
            check("start_ready", bus.tx_ready, 1);
            check("start_gap", prev_start, 0);
            rx.push_back(bus.tx_data);
            busy = busy_time;
        end else if (busy > 0) busy--;
        if (hold_low) begin
            if (bus.tx_start) hold_starts++;
            if (bus.adc_rd_en) hold_rd++;
            if (bus.tx_data !== hold_data) hold_chg++;
        end
        if (watch_busy && !bus.gen_busy) busy_drop++;
        if (bus.burst_active && !prev_burst) n_bursts++;
        if (!bus.burst_active && prev_burst) drop_cyc = cyc;
        prev_start = bus.tx_start;
        prev_burst = bus.burst_active;
        bus.tx_ready = (busy == 0) && !hold_low;
        bus.adc_empty = (fifo.size() == 0);
    end

    task automatic load(input int n, input bit seq);
        for (int i = 0; i < n; i++) begin
            logic [7:0] b;
            b = seq ? 8'(i) : 8'($urandom);
            fifo.push_back(b);
            src.push_back(b);
        end
    endtask

    function automatic void expect_bursts(input int from, input int n);
        for (int i = 0; i < n; i++) begin
            if (HDR != 0 && i % BL == 0) exp_q.push_back(8'hA5);
            exp_q.push_back(src[from + i]);
        end
    endfunction

    task automatic gen_wr(input logic [7:0] v);
        @(negedge clk);
        bus.gen_data = v;
        bus.gen_write = 1'b1;
        @(negedge clk);
        bus.gen_write = 1'b0;
    endtask

    task automatic wait_rx(input string tag, input int n, input int budget);
        int k = 0;
        while (k < budget && rx.size() < n) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_rx_timeout"}, k < budget, 1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (k < budget && (rx.size() < exp_q.size() || bus.burst_active || bus.gen_busy || !bus.tx_ready)) begin
            @(negedge clk);
            k++;
        end
        check({tag, "_timeout"}, k < budget, 1);
        repeat (4) @(negedge clk);
    endtask

    task automatic compare(input string tag);
        check({tag, "_len"}, rx.size(), exp_q.size());
        for (int i = 0; i < rx.size() && i < exp_q.size(); i++)
            check($sformatf("%s_byte%0d", tag, i), rx[i], exp_q[i]);
        rx.delete();
        exp_q.delete();
        src.delete();
        n_rd = 0;
        n_bursts = 0;
    endtask

    function automatic int budget_for(input int n);
        return (n / BL + 2) * (SM + 60) + n * 40 + 200;
    endfunction

    initial begin
        bus.adc_empty = 1'b1;
        bus.adc_data = 8'h00;
        bus.gen_data = 8'h00;
        bus.gen_write = 1'b0;
        bus.tx_ready = 1'b1;
        #1;
        check("rst_tx_start", bus.tx_start, 0);
        check("rst_rd_en", bus.adc_rd_en, 0);
        check("rst_tx_data", bus.tx_data, 0);
        check("rst_gen_busy", bus.gen_busy, 0);
        check("rst_burst", bus.burst_active, 0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // 40 sequential bytes, fixed busy time: bursts 0..15, 16..31, 32..39 + abort
        busy_time = 10;
        load(40, 1);
        expect_bursts(0, 40);
        wait_done("seq40", budget_for(40));
        check("seq40_rd_count", n_rd, 40);
        check("seq40_bursts", n_bursts, 3);
        check("seq40_abort_min", (drop_cyc - last_rd_cyc) >= SM, 1);
        check("seq40_abort_max", (drop_cyc - last_rd_cyc) <= SM + 40, 1);
        compare("seq40");

        // general byte pending before the FIFO fills wins the UART
        gen_wr(8'h55);
        load(5, 0);
        exp_q.push_back(8'h55);
        expect_bursts(0, 5);
        wait_done("gen_first", budget_for(5));
        check("gen_first_bursts", n_bursts, 1);
        check("gen_first_rd", n_rd, 5);
        compare("gen_first");

        // general writes mid-burst are deferred; the second is dropped
        busy_time = $urandom_range(3, 12);
        load(BL, 0);
        expect_bursts(0, BL);
        exp_q.push_back(8'h33);
        wait_rx("midburst", HDR + 4, 2000);
        gen_wr(8'h33);
        watch_busy = 1;
        check("midburst_busy", bus.gen_busy, 1);
        repeat (5) @(negedge clk);
        gen_wr(8'h44);
        wait_rx("midburst_end", HDR + BL, 4000);
        watch_busy = 0;
        check("midburst_busy_held", busy_drop, 0);
        check("midburst_burst_on", bus.burst_active, 1);
        wait_done("midburst", budget_for(BL));
        compare("midburst");

        // UART stuck busy: arbiter must sit still
        busy_time = 10;
        load(3, 0);
        expect_bursts(0, 3);
        wait_rx("stuck", HDR + 1, 2000);
        hold_data = src[0];
        hold_low = 1;
        repeat (500) @(negedge clk);
        hold_low = 0;
        check("stuck_starts", hold_starts, 0);
        check("stuck_rd", hold_rd, 0);
        check("stuck_data_chg", hold_chg, 0);
        wait_done("stuck", budget_for(3));
        compare("stuck");

        // reset in TX_WAIT of burst byte 7 discards hold byte and restarts the count
        busy_time = 10;
        load(24, 0);
        expect_bursts(0, 8);
        wait_rx("rst_mid", HDR + 3, 2000);
        gen_wr(8'h77);
        wait_rx("rst_mid", HDR + 8, 4000);
        rst_n = 1'b0;
        #1;
        check("rst_mid_tx_start", bus.tx_start, 0);
        check("rst_mid_rd_en", bus.adc_rd_en, 0);
        check("rst_mid_tx_data", bus.tx_data, 0);
        check("rst_mid_gen_busy", bus.gen_busy, 0);
        check("rst_mid_burst", bus.burst_active, 0);
        repeat (2) @(negedge clk);
        n_rd = 0;
        n_bursts = 0;
        rst_n = 1'b1;
        @(posedge clk);
        #1 check("rst_sync_edge1", bus.burst_active, 0);
        @(posedge clk);
        #1 check("rst_sync_edge2", bus.burst_active, 1);
        expect_bursts(8, 16);
        wait_done("rst_mid", budget_for(16));
        check("rst_mid_bursts", n_bursts, 1);
        check("rst_mid_rd", n_rd, 16);
        compare("rst_mid");

        // randomized fill levels and UART busy times
        for (int r = 0; r < 4; r++) begin
            int n;
            n = $urandom_range(1, 40);
            busy_time = $urandom_range(2, 14);
            load(n, 0);
            expect_bursts(0, n);
            wait_done($sformatf("rand%0d", r), budget_for(n));
            check($sformatf("rand%0d_rd", r), n_rd, n);
            check($sformatf("rand%0d_bursts", r), n_bursts, (n + BL - 1) / BL);
            compare($sformatf("rand%0d", r));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
